// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Small single-port data memory behind a valid/ready request channel and a
// valid/ready response channel. Each accepted request produces exactly one
// registered response in the following cycle. Loads are sign- or zero-extended
// and stores write only the addressed bytes.
//
// Parameters
//   XLEN   : data width in bits (32 or 64)
//   DEPTH  : number of XLEN-bit words (power of two, >= 2)
//   ADDR_W : byte-address width
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   req_valid    : request present
//   req_ready    : controller can take a request (IDLE)
//   req_we       : 1 = store, 0 = load
//   req_size     : 0 byte, 1 half, 2 word, 3 double
//   req_unsigned : load zero-extends when 1, sign-extends when 0
//   req_addr     : byte address
//   req_wdata    : store data, right-aligned
//   rsp_valid    : response present (RESP)
//   rsp_ready    : consumer takes the response
//   rsp_rdata    : load result; 0 for stores and faults
//   rsp_fault    : access faulted
//
// Configuration macro
//   DMEM_ALIGN_CHECK_EN : when defined, misaligned accesses fault; otherwise
//                         the low address bits are cleared to align them.
module data_mem_ctrl #(
    parameter int XLEN   = 64,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault
);

    localparam int NB     = XLEN / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_LSB = OFF_W + IDX_W;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state;

    logic [XLEN-1:0] mem [DEPTH];

    logic [OFF_W-1:0] raw_off;
    logic [OFF_W-1:0] size_mask;
    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [NB-1:0]    size_be;
    logic [NB-1:0]    byte_en;
    logic             range_fault;
    logic             size_fault;
    logic             align_fault;
    logic             fault;
    logic             accept;
    logic [XLEN-1:0]  word;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_val;
    logic [XLEN-1:0]  store_data;

    // Address decode, fault detection, byte-lane alignment and load extension.
    // Everything here is sampled into registers at acceptance, so no req_*
    // input ever reaches a rsp_* output combinationally.
    always_comb begin
        raw_off     = req_addr[OFF_W-1:0];
        idx         = req_addr[HI_LSB-1:OFF_W];
        range_fault = |(req_addr >> HI_LSB);
        size_fault  = (req_size == 2'd3) && (XLEN == 32);

        case (req_size)
            2'd0: begin
                size_mask = '0;
                size_be   = NB'(1);
            end
            2'd1: begin
                size_mask = OFF_W'(1);
                size_be   = NB'(3);
            end
            2'd2: begin
                size_mask = OFF_W'(3);
                size_be   = NB'(8'h0F);
            end
            default: begin
                size_mask = OFF_W'(7);
                size_be   = NB'(8'hFF);
            end
        endcase

`ifdef DMEM_ALIGN_CHECK_EN
        align_fault = |(raw_off & size_mask);
        off         = raw_off;
`else
        // Clearing the low size bits turns every access into a naturally
        // aligned one, so it can never straddle a word.
        align_fault = 1'b0;
        off         = raw_off & ~size_mask;
`endif

        fault      = range_fault | size_fault | align_fault;
        accept     = req_valid && req_ready;
        byte_en    = size_be << off;
        word       = mem[idx];
        shifted    = word >> {off, 3'b000};
        store_data = req_wdata << {off, 3'b000};

        load_val = shifted;
        case (req_size)
            2'd0: begin
                if (req_unsigned) load_val = XLEN'(shifted[7:0]);
                else              load_val = XLEN'($signed(shifted[7:0]));
            end
            2'd1: begin
                if (req_unsigned) load_val = XLEN'(shifted[15:0]);
                else              load_val = XLEN'($signed(shifted[15:0]));
            end
            2'd2: begin
                if (req_unsigned) load_val = XLEN'(shifted[31:0]);
                else              load_val = XLEN'($signed(shifted[31:0]));
            end
            default: load_val = shifted;
        endcase
    end

    // Handshake FSM. Response outputs are loaded only on acceptance, so they
    // stay frozen while the consumer stalls in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= RESP;
                        req_ready <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= fault;
                        rsp_rdata <= (fault || req_we) ? '0 : load_val;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Storage. Reset loads word i with the value i. A store writes only its
    // enabled byte lanes and a faulting store is dropped entirely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= XLEN'(i);
            end
        end else if (accept && req_we && !fault) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) begin
                    mem[idx][b*8 +: 8] <= store_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
// Self-checking bench for data_mem_ctrl at the default configuration
// (XLEN=64, DEPTH=32, ADDR_W=64). Expected responses are queued when a
// request is accepted and compared when the DUT presents its response.
module tb_data_mem_ctrl;

    localparam int XLEN   = 64;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 64;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_fault;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          tag;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    int checks;
    int errors;
    int tag_cnt;

    data_mem_ctrl #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_fault   (rsp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] exp_rdata, input logic exp_fault);
        vec_t v;
        v.we        = we;
        v.size      = size;
        v.uns       = uns;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_fault = exp_fault;
        return v;
    endfunction

    // Drive one request, wait (bounded) for acceptance, queue its expectation.
    task automatic applyStimulus(input vec_t v);
        int   cnt;
        exp_t e;
        @(negedge clk);
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: req_ready stuck at 0, expected 1");
        end else begin
            e.rdata = v.exp_rdata;
            e.fault = v.exp_fault;
            e.tag   = tag_cnt;
            tag_cnt++;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int cnt;
        cnt = 0;
        while (sb.size() > 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d responses pending, expected 0", sb.size());
        end
    endtask

    // Response monitor: a response completes on the next rising edge when
    // rsp_valid and rsp_ready are both high mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: rsp_valid=1 with no pending request, expected 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput($sformatf("rsp%0d_rdata", e.tag), rsp_rdata, e.rdata);
                    checkOutput($sformatf("rsp%0d_fault", e.tag), 64'(rsp_fault), 64'(e.fault));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] lw0a_rdata;
        logic        lw0a_fault;
        logic [63:0] lh13_rdata;
        logic        lh13_fault;

        checks       = 0;
        errors       = 0;
        tag_cnt      = 0;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;

`ifdef DMEM_ALIGN_CHECK_EN
        lw0a_rdata = 64'h0;
        lw0a_fault = 1'b1;
        lh13_rdata = 64'h0;
        lh13_fault = 1'b1;
`else
        lw0a_rdata = 64'h0000_0000_0000_AB01;
        lw0a_fault = 1'b0;
        lh13_rdata = 64'hFFFF_FFFF_FFFF_8001;
        lh13_fault = 1'b0;
`endif

        //          we    size  uns   addr        wdata          exp_rdata                 fault
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 64'h18,  64'h0,         64'h3,                     1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 64'h09,  64'hAB,        64'h0,                     1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 64'h09,  64'h0,         64'hAB,                    1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 64'h09,  64'h0,         64'hFFFF_FFFF_FFFF_FFAB,   1'b0));
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 64'h08,  64'h0,         64'h0000_0000_0000_AB01,   1'b0));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 64'h0A,  64'h0,         lw0a_rdata,                lw0a_fault));
        vecs.push_back(mk(1'b1, 2'd3, 1'b0, 64'h100, 64'hDEAD,      64'h0,                     1'b1));
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 64'h00,  64'h0,         64'h0,                     1'b0));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 64'h12,  64'h8001,      64'h0,                     1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 64'h12,  64'h0,         64'hFFFF_FFFF_FFFF_8001,   1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 1'b1, 64'h12,  64'h0,         64'h8001,                  1'b0));
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 64'h10,  64'h0,         64'h0000_0000_8001_0002,   1'b0));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 64'h1C,  64'hFFFF_FFFF, 64'h0,                     1'b0));
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 64'h1C,  64'h0,         64'hFFFF_FFFF_FFFF_FFFF,   1'b0));
        vecs.push_back(mk(1'b0, 2'd2, 1'b1, 64'h1C,  64'h0,         64'h0000_0000_FFFF_FFFF,   1'b0));
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 64'h18,  64'h0,         64'hFFFF_FFFF_0000_0003,   1'b0));
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 64'hF8,  64'h0,         64'h1F,                    1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 64'h200, 64'h0,         64'h0,                     1'b1));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 64'h13,  64'h0,         lh13_rdata,                lh13_fault));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 64'h1FF, 64'h77,        64'h0,                     1'b1));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 64'hFF,  64'h0,         64'h0,                     1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 64'hF8,  64'h1234,      64'h0,                     1'b0));
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 64'hF8,  64'h0,         64'h34,                    1'b0));

        // Outputs while reset is held low.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", 64'(req_ready), 64'h1);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 64'h0);
        checkOutput("reset_rsp_fault", 64'(rsp_fault), 64'h0);
        reset = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end
        waitDrain();

        // Consumer stalls for three cycles; a second request waits meanwhile.
        $display("[TB] response back-pressure");
        rsp_ready = 1'b0;
        applyStimulus(mk(1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'h0000_0000_0000_AB01, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_we       = 1'b0;
                req_size     = 2'd3;
                req_unsigned = 1'b0;
                req_addr     = 64'h18;
                req_wdata    = 64'h0;
                req_valid    = 1'b1;
            end
            #1;
            checkOutput($sformatf("stall%0d_rsp_valid", k), 64'(rsp_valid), 64'h1);
            checkOutput($sformatf("stall%0d_req_ready", k), 64'(req_ready), 64'h0);
            checkOutput($sformatf("stall%0d_rsp_rdata", k), rsp_rdata, 64'h0000_0000_0000_AB01);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        applyStimulus(mk(1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'hFFFF_FFFF_0000_0003, 1'b0));
        waitDrain();

        // Reset arrives while a response is pending; memory is reinitialised.
        $display("[TB] reset during response");
        applyStimulus(mk(1'b1, 2'd3, 1'b0, 64'h08, 64'h55, 64'h0, 1'b0));
        waitDrain();
        rsp_ready = 1'b0;
        applyStimulus(mk(1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'h55, 1'b0));
        @(negedge clk);
        #4;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("async_rst_req_ready", 64'(req_ready), 64'h1);
        checkOutput("async_rst_rsp_rdata", rsp_rdata, 64'h0);
        sb.delete();
        @(negedge clk);
        reset     = 1'b1;
        rsp_ready = 1'b1;
        applyStimulus(mk(1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'h1, 1'b0));
        applyStimulus(mk(1'b0, 2'd3, 1'b0, 64'hF8, 64'h0, 64'h1F, 1'b0));
        waitDrain();

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 32, number of XLEN-bit words; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
REQ-012 req_addr  input  ADDR_W  byte address.
REQ-013 req_wdata  input  XLEN  store data, right-aligned.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer accepts the response.
REQ-016 rsp_rdata  output  XLEN  load result, extended per REQ-011; 0 for stores and for faults.
REQ-017 rsp_fault  output  1  access faulted.

Function
REQ-018 SHALL be a two-state FSM with states IDLE and RESP.
REQ-019 IDLE: req_ready = 1, rsp_valid = 0; on req_valid go to RESP (accept).
REQ-020 RESP: req_ready = 0, rsp_valid = 1; on rsp_ready return to IDLE; otherwise hold all response outputs stable.
REQ-021 Latency SHALL be 1 cycle: the response is valid in the cycle after acceptance.
REQ-022 The word index is the log2(DEPTH) address bits directly above the log2(XLEN/8) byte-offset bits.
REQ-023 The byte lane is the low log2(XLEN/8) address bits.
REQ-024 An access SHALL fault when any address bit above the word-index field is nonzero (out of range).
REQ-025 An access SHALL fault when req_size = 3 and XLEN = 32.
REQ-026 A store SHALL update only the addressed bytes, on the accept edge; the other bytes of the word are preserved.
REQ-027 A faulting store SHALL leave memory unchanged.
REQ-028 A load SHALL read the memory state before any store in the same edge; no such store is possible under this handshake.
REQ-029 Results SHALL be captured in registers at acceptance; there is no combinational path from req_* to rsp_*.

Reset
REQ-030 While reset is low: FSM in IDLE, rsp_valid = 0, rsp_fault = 0, rsp_rdata = 0, req_ready = 1.
REQ-031 While reset is low, memory word i SHALL be initialised to the value i, zero-extended.
REQ-032 Reset asserted in RESP SHALL discard the pending response; a store already accepted remains overwritten by the REQ-031 initialisation.

Configuration
REQ-033 Macro DMEM_ALIGN_CHECK_EN, when defined: an access whose address is not a multiple of its size SHALL fault, with no memory update and rsp_rdata = 0.
REQ-034 When DMEM_ALIGN_CHECK_EN is undefined: the low log2(size) address bits SHALL be forced to zero (naturally aligned access), and misalignment never faults.

Verification
REQ-035 Scenario 1: after reset, LD at 0x18 (XLEN=64, DEPTH=32) -> rsp_rdata = 0x3 and rsp_fault = 0 one cycle after acceptance.
REQ-036 Scenario 2: SB 0xAB at 0x09, then LBU 0x09, then LB 0x09, then LD 0x08 -> 0xAB, then 0xFFFFFFFFFFFFFFAB, then 0x000000000000AB01.
REQ-037 Scenario 3: LW at 0x0A -> with macro: rsp_fault = 1 and rsp_rdata = 0; without macro: rsp_rdata = 0x000000000000AB01 (read as if at 0x08).
REQ-038 Scenario 4: SD 0xDEAD at 0x100 -> rsp_fault = 1, and a following LD at 0x00 still returns 0x0.
REQ-039 Scenario 5: rsp_ready held low for 3 cycles -> rsp_valid stays 1, rsp_rdata stays stable and req_ready stays 0; the new request is accepted only in IDLE.
REQ-040 Scenario 6: reset pulsed low while in RESP -> rsp_valid = 0 immediately (asynchronous), and LD at 0x08 after release returns 0x1.
